// File: rtl/pong_pkg.sv
// Shared pong definitions: playfield defaults, position width, paddle bounds and FSM encoding.
package pong_pkg;

    localparam int unsigned SCR_W_DEF    = 32;
    localparam int unsigned SCR_H_DEF    = 20;
    localparam int unsigned PADDLE_H_DEF = 6;
    localparam int unsigned POS_W        = 11;

    typedef enum logic {
        IDLE = 1'b0,
        HELD = 1'b1
    } paddle_st_t;

    function automatic logic [POS_W-1:0] p_min();
        return POS_W'(1);
    endfunction

    function automatic logic [POS_W-1:0] p_max(input int unsigned scr_h,
                                               input int unsigned paddle_h);
        return POS_W'(scr_h - 1 - paddle_h);
    endfunction

    function automatic logic [POS_W-1:0] p_init(input int unsigned scr_h,
                                                input int unsigned paddle_h);
        return POS_W'((scr_h - paddle_h) >> 1);
    endfunction

    // One-row move that saturates at the playfield bounds.
    function automatic logic [POS_W-1:0] pos_step(input logic [POS_W-1:0] pos,
                                                  input logic             up,
                                                  input logic [POS_W-1:0] lo,
                                                  input logic [POS_W-1:0] hi);
        if (up) return (pos <= lo) ? lo : pos - 1'b1;
        return (pos >= hi) ? hi : pos + 1'b1;
    endfunction

endpackage

// File: rtl/btn_debounce.sv
// One player button: 2-FF synchroniser, debounce counter, registered rise and fall pulses.
module btn_debounce #(
    parameter int unsigned DEB_CYCLES = 750000
) (
    input  logic CLK,
    input  logic RST_N,
    input  logic raw,
    output logic level,
    output logic pulse,
    output logic fall
);

    localparam int unsigned CNT_W = (DEB_CYCLES > 1) ? $clog2(DEB_CYCLES) : 1;

    logic [1:0]       sync_q;
    logic [CNT_W-1:0] cnt_q;
    logic             level_q;
    logic             pulse_q;
    logic             fall_q;
    logic             toggle;

    assign toggle = (sync_q[1] != level_q) && (cnt_q == CNT_W'(DEB_CYCLES - 1));

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            sync_q  <= '0;
            cnt_q   <= '0;
            level_q <= 1'b0;
            pulse_q <= 1'b0;
            fall_q  <= 1'b0;
        end else begin
            sync_q <= {sync_q[0], raw};
            if (sync_q[1] == level_q || toggle) begin
                cnt_q <= '0;
            end else begin
                cnt_q <= cnt_q + 1'b1;
            end
            if (toggle) begin
                level_q <= ~level_q;
            end
            // Edge pulses line up with the first cycle of the new level.
            pulse_q <= toggle && !level_q;
            fall_q  <= toggle && level_q;
        end
    end

    assign level = level_q;
    assign pulse = pulse_q;
    assign fall  = fall_q;

endmodule

// File: rtl/paddle_ctrl.sv
// Button conditioning and paddle positions for pong; PADDLE_AI_EN adds an AI-driven right paddle.
module paddle_ctrl
    import pong_pkg::*;
#(
    parameter int unsigned SCR_H      = SCR_H_DEF,
    parameter int unsigned PADDLE_H   = PADDLE_H_DEF,
    parameter int unsigned DEB_CYCLES = 750000,
    parameter int unsigned MOVE_DIV   = 7500000
) (
    input  logic             CLK,
    input  logic             RST_N,
    input  logic             A_UP_RAW,
    input  logic             A_DOWN_RAW,
    input  logic             B_UP_RAW,
    input  logic             B_DOWN_RAW,
    input  logic             HOLD,
`ifdef PADDLE_AI_EN
    input  logic             AI_MODE,
    input  logic [POS_W-1:0] V_BALL_POSITION,
`endif
    output logic             A_up,
    output logic             A_down,
    output logic             B_up,
    output logic             B_down,
    output logic             A_up_p,
    output logic             A_down_p,
    output logic             B_up_p,
    output logic             B_down_p,
    output logic [POS_W-1:0] L_PADDLE_POSITION,
    output logic [POS_W-1:0] R_PADDLE_POSITION
);

    localparam int unsigned      MOV_W    = (MOVE_DIV > 1) ? $clog2(MOVE_DIV) : 1;
    localparam logic [POS_W-1:0] P_MIN_V  = p_min();
    localparam logic [POS_W-1:0] P_MAX_V  = p_max(SCR_H, PADDLE_H);
    localparam logic [POS_W-1:0] P_INIT_V = p_init(SCR_H, PADDLE_H);

    // Index 0 is the left paddle (A buttons), index 1 the right paddle (B buttons).
    logic [1:0] up_l, dn_l, up_p, dn_p, up_f, dn_f;

    btn_debounce #(.DEB_CYCLES(DEB_CYCLES)) u_a_up (
        .CLK(CLK), .RST_N(RST_N), .raw(A_UP_RAW),
        .level(up_l[0]), .pulse(up_p[0]), .fall(up_f[0])
    );
    btn_debounce #(.DEB_CYCLES(DEB_CYCLES)) u_a_down (
        .CLK(CLK), .RST_N(RST_N), .raw(A_DOWN_RAW),
        .level(dn_l[0]), .pulse(dn_p[0]), .fall(dn_f[0])
    );
    btn_debounce #(.DEB_CYCLES(DEB_CYCLES)) u_b_up (
        .CLK(CLK), .RST_N(RST_N), .raw(B_UP_RAW),
        .level(up_l[1]), .pulse(up_p[1]), .fall(up_f[1])
    );
    btn_debounce #(.DEB_CYCLES(DEB_CYCLES)) u_b_down (
        .CLK(CLK), .RST_N(RST_N), .raw(B_DOWN_RAW),
        .level(dn_l[1]), .pulse(dn_p[1]), .fall(dn_f[1])
    );

    for (genvar i = 0; i < 2; i++) begin : g_paddle
        paddle_st_t       st_q;
        logic             dir_up_q;
        logic [MOV_W-1:0] rep_q;
        logic [POS_W-1:0] pos_q;
        logic             held_l, opp_l, rep_wrap, ai_on;
        logic [POS_W-1:0] ai_next;

        assign held_l   = dir_up_q ? up_l[i] : dn_l[i];
        assign opp_l    = dir_up_q ? dn_l[i] : up_l[i];
        assign rep_wrap = (rep_q == MOV_W'(MOVE_DIV - 1));

`ifdef PADDLE_AI_EN
        logic [POS_W-1:0] ai_tgt;

        always_comb begin
            ai_tgt = V_BALL_POSITION - POS_W'(PADDLE_H / 2);
            if (V_BALL_POSITION < POS_W'(PADDLE_H / 2) + P_MIN_V) begin
                ai_tgt = P_MIN_V;
            end else if (ai_tgt > P_MAX_V) begin
                ai_tgt = P_MAX_V;
            end
            if (ai_tgt < pos_q) begin
                ai_next = pos_q - 1'b1;
            end else if (ai_tgt > pos_q) begin
                ai_next = pos_q + 1'b1;
            end else begin
                ai_next = pos_q;
            end
        end

        assign ai_on = (i == 1) && AI_MODE;
`else
        assign ai_on   = 1'b0;
        assign ai_next = pos_q;
`endif

        always_ff @(posedge CLK or negedge RST_N) begin
            if (!RST_N) begin
                st_q     <= IDLE;
                dir_up_q <= 1'b0;
                rep_q    <= '0;
                pos_q    <= P_INIT_V;
            end else if (HOLD) begin
                st_q  <= IDLE;
                rep_q <= '0;
            end else if (ai_on) begin
                st_q <= IDLE;
                if (rep_wrap) begin
                    rep_q <= '0;
                    pos_q <= ai_next;
                end else begin
                    rep_q <= rep_q + 1'b1;
                end
            end else begin
                case (st_q)
                    IDLE: begin
                        rep_q <= '0;
                        if (up_p[i] && !dn_l[i]) begin
                            st_q     <= HELD;
                            dir_up_q <= 1'b1;
                            pos_q    <= pos_step(pos_q, 1'b1, P_MIN_V, P_MAX_V);
                        end else if (dn_p[i] && !up_l[i]) begin
                            st_q     <= HELD;
                            dir_up_q <= 1'b0;
                            pos_q    <= pos_step(pos_q, 1'b0, P_MIN_V, P_MAX_V);
                        end else if (up_l[i] && !dn_l[i] && dn_f[i]) begin
                            // Opposite button released: resume repeat without an immediate step.
                            st_q     <= HELD;
                            dir_up_q <= 1'b1;
                        end else if (dn_l[i] && !up_l[i] && up_f[i]) begin
                            st_q     <= HELD;
                            dir_up_q <= 1'b0;
                        end
                    end
                    HELD: begin
                        if (!held_l || opp_l) begin
                            st_q  <= IDLE;
                            rep_q <= '0;
                        end else if (rep_wrap) begin
                            rep_q <= '0;
                            pos_q <= pos_step(pos_q, dir_up_q, P_MIN_V, P_MAX_V);
                        end else begin
                            rep_q <= rep_q + 1'b1;
                        end
                    end
                    default: st_q <= IDLE;
                endcase
            end
        end
    end

    assign A_up     = up_l[0];
    assign A_down   = dn_l[0];
    assign B_up     = up_l[1];
    assign B_down   = dn_l[1];
    assign A_up_p   = up_p[0];
    assign A_down_p = dn_p[0];
    assign B_up_p   = up_p[1];
    assign B_down_p = dn_p[1];

    assign L_PADDLE_POSITION = g_paddle[0].pos_q;
    assign R_PADDLE_POSITION = g_paddle[1].pos_q;

endmodule

// File: tb/tb_paddle_ctrl.sv
// Directed bench for paddle_ctrl with DEB_CYCLES=4, MOVE_DIV=8.
module tb_paddle_ctrl;

    logic        CLK;
    logic        RST_N;
    logic        A_UP_RAW, A_DOWN_RAW, B_UP_RAW, B_DOWN_RAW;
    logic        HOLD;
    logic        A_up, A_down, B_up, B_down;
    logic        A_up_p, A_down_p, B_up_p, B_down_p;
    logic [10:0] L_PADDLE_POSITION, R_PADDLE_POSITION;
`ifdef PADDLE_AI_EN
    logic        AI_MODE;
    logic [10:0] V_BALL_POSITION;
`endif

    int n_pass;
    int n_total;

    paddle_ctrl #(
        .SCR_H(20), .PADDLE_H(6), .DEB_CYCLES(4), .MOVE_DIV(8)
    ) dut (
        .CLK(CLK), .RST_N(RST_N),
        .A_UP_RAW(A_UP_RAW), .A_DOWN_RAW(A_DOWN_RAW),
        .B_UP_RAW(B_UP_RAW), .B_DOWN_RAW(B_DOWN_RAW),
        .HOLD(HOLD),
`ifdef PADDLE_AI_EN
        .AI_MODE(AI_MODE), .V_BALL_POSITION(V_BALL_POSITION),
`endif
        .A_up(A_up), .A_down(A_down), .B_up(B_up), .B_down(B_down),
        .A_up_p(A_up_p), .A_down_p(A_down_p), .B_up_p(B_up_p), .B_down_p(B_down_p),
        .L_PADDLE_POSITION(L_PADDLE_POSITION), .R_PADDLE_POSITION(R_PADDLE_POSITION)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, time %0t limit 200000", $time);
        $fatal(1);
    end

    task automatic step();
        @(posedge CLK);
        #1;
    endtask

    task automatic do_reset();
        RST_N = 1'b0;
        A_UP_RAW = 1'b0; A_DOWN_RAW = 1'b0; B_UP_RAW = 1'b0; B_DOWN_RAW = 1'b0;
        HOLD = 1'b0;
`ifdef PADDLE_AI_EN
        AI_MODE = 1'b0;
        V_BALL_POSITION = 11'd0;
`endif
        repeat (3) @(posedge CLK);
        #1;
        RST_N = 1'b1;
        step();
    endtask

    task automatic test_reset();
        do_reset();
        n_total++;
        if (L_PADDLE_POSITION !== 11'd7)
            $display("FAIL reset_L: got %0d want 7", L_PADDLE_POSITION);
        else n_pass++;
        n_total++;
        if (R_PADDLE_POSITION !== 11'd7)
            $display("FAIL reset_R: got %0d want 7", R_PADDLE_POSITION);
        else n_pass++;
        n_total++;
        if ({A_up, A_down, B_up, B_down} !== 4'b0000)
            $display("FAIL reset_levels: got %b want 0000", {A_up, A_down, B_up, B_down});
        else n_pass++;
        n_total++;
        if ({A_up_p, A_down_p, B_up_p, B_down_p} !== 4'b0000)
            $display("FAIL reset_pulses: got %b want 0000", {A_up_p, A_down_p, B_up_p, B_down_p});
        else n_pass++;
    endtask

    task automatic test_glitch();
        int seen;
        seen = 0;
        do_reset();
        A_UP_RAW = 1'b1;
        for (int c = 1; c <= 18; c++) begin
            step();
            if (c == 3) A_UP_RAW = 1'b0;
            if (A_up_p || A_up) seen++;
        end
        n_total++;
        if (seen !== 0) $display("FAIL glitch_pulse: got %0d active cycles want 0", seen);
        else n_pass++;
        n_total++;
        if (L_PADDLE_POSITION !== 11'd7)
            $display("FAIL glitch_L: got %0d want 7", L_PADDLE_POSITION);
        else n_pass++;
    endtask

    task automatic test_press();
        int first_p, n_p;
        logic [10:0] l6, l7, l14, l15;
        first_p = -1; n_p = 0;
        do_reset();
        A_UP_RAW = 1'b1;
        for (int c = 1; c <= 20; c++) begin
            step();
            if (A_up_p) begin
                n_p++;
                if (first_p < 0) first_p = c;
            end
            if (c == 6)  l6  = L_PADDLE_POSITION;
            if (c == 7)  l7  = L_PADDLE_POSITION;
            if (c == 14) l14 = L_PADDLE_POSITION;
            if (c == 15) l15 = L_PADDLE_POSITION;
        end
        n_total++;
        if (first_p !== 6) $display("FAIL press_pulse_cycle: got %0d want 6", first_p);
        else n_pass++;
        n_total++;
        if (n_p !== 1) $display("FAIL press_pulse_count: got %0d want 1", n_p);
        else n_pass++;
        n_total++;
        if (l6 !== 11'd7) $display("FAIL press_L_c6: got %0d want 7", l6);
        else n_pass++;
        n_total++;
        if (l7 !== 11'd6) $display("FAIL press_L_c7: got %0d want 6", l7);
        else n_pass++;
        n_total++;
        if (l14 !== 11'd6) $display("FAIL press_L_c14: got %0d want 6", l14);
        else n_pass++;
        n_total++;
        if (l15 !== 11'd5) $display("FAIL press_L_c15: got %0d want 5", l15);
        else n_pass++;
    endtask

    task automatic test_repeat();
        int exp;
        do_reset();
        A_DOWN_RAW = 1'b1;
        for (int c = 1; c <= 100; c++) begin
            step();
            if (c < 7) exp = 7;
            else exp = 8 + (c - 7) / 8;
            if (exp > 13) exp = 13;
            n_total++;
            if (L_PADDLE_POSITION !== 11'(exp))
                $display("FAIL repeat_L_c%0d: got %0d want %0d", c, L_PADDLE_POSITION, exp);
            else n_pass++;
        end
    endtask

    task automatic test_both();
        logic [10:0] r5, r6, r14, r15;
        logic lvl5, lvl6;
        do_reset();
        B_UP_RAW = 1'b1;
        B_DOWN_RAW = 1'b1;
        repeat (30) step();
        n_total++;
        if ({B_up, B_down} !== 2'b11) $display("FAIL both_levels: got %b want 11", {B_up, B_down});
        else n_pass++;
        n_total++;
        if (R_PADDLE_POSITION !== 11'd7)
            $display("FAIL both_R_hold: got %0d want 7", R_PADDLE_POSITION);
        else n_pass++;
        B_DOWN_RAW = 1'b0;
        for (int c = 1; c <= 15; c++) begin
            step();
            if (c == 5)  begin lvl5 = B_down; r5 = R_PADDLE_POSITION; end
            if (c == 6)  begin lvl6 = B_down; r6 = R_PADDLE_POSITION; end
            if (c == 14) r14 = R_PADDLE_POSITION;
            if (c == 15) r15 = R_PADDLE_POSITION;
        end
        n_total++;
        if ({lvl5, lvl6} !== 2'b10) $display("FAIL both_down_fall: got %b want 10", {lvl5, lvl6});
        else n_pass++;
        n_total++;
        if ({r5, r6, r14} !== {11'd7, 11'd7, 11'd7})
            $display("FAIL both_R_keep: got %0d %0d %0d want 7 7 7", r5, r6, r14);
        else n_pass++;
        n_total++;
        if (r15 !== 11'd6) $display("FAIL both_R_resume: got %0d want 6", r15);
        else n_pass++;
        n_total++;
        if (L_PADDLE_POSITION !== 11'd7)
            $display("FAIL both_L_untouched: got %0d want 7", L_PADDLE_POSITION);
        else n_pass++;
    endtask

    task automatic test_hold();
        int first_p, n_p, moved;
        logic [10:0] l6, l7;
        first_p = -1; n_p = 0; moved = 0;
        do_reset();
        HOLD = 1'b1;
        A_DOWN_RAW = 1'b1;
        for (int c = 1; c <= 20; c++) begin
            step();
            if (A_down_p) begin
                n_p++;
                if (first_p < 0) first_p = c;
            end
            if (L_PADDLE_POSITION !== 11'd7) moved++;
        end
        n_total++;
        if (first_p !== 6 || n_p !== 1)
            $display("FAIL hold_pulse: got cycle %0d count %0d want cycle 6 count 1", first_p, n_p);
        else n_pass++;
        n_total++;
        if (A_down !== 1'b1) $display("FAIL hold_level: got %b want 1", A_down);
        else n_pass++;
        HOLD = 1'b0;
        repeat (20) begin
            step();
            if (L_PADDLE_POSITION !== 11'd7) moved++;
        end
        n_total++;
        if (moved !== 0) $display("FAIL hold_frozen: got %0d moved cycles want 0", moved);
        else n_pass++;
        A_DOWN_RAW = 1'b0;
        repeat (10) step();
        A_DOWN_RAW = 1'b1;
        for (int c = 1; c <= 7; c++) begin
            step();
            if (c == 6) l6 = L_PADDLE_POSITION;
            if (c == 7) l7 = L_PADDLE_POSITION;
        end
        n_total++;
        if (l6 !== 11'd7) $display("FAIL hold_repress_c6: got %0d want 7", l6);
        else n_pass++;
        n_total++;
        if (l7 !== 11'd8) $display("FAIL hold_repress_c7: got %0d want 8", l7);
        else n_pass++;
    endtask

    task automatic test_reset_mid();
        logic p6;
        logic [10:0] l7;
        do_reset();
        A_DOWN_RAW = 1'b1;
        repeat (23) step();
        n_total++;
        if (L_PADDLE_POSITION !== 11'd10)
            $display("FAIL mid_L_before: got %0d want 10", L_PADDLE_POSITION);
        else n_pass++;
        #2;
        RST_N = 1'b0;
        #1;
        n_total++;
        if (L_PADDLE_POSITION !== 11'd7)
            $display("FAIL mid_L_async: got %0d want 7", L_PADDLE_POSITION);
        else n_pass++;
        n_total++;
        if ({A_down, A_down_p} !== 2'b00)
            $display("FAIL mid_outputs: got %b want 00", {A_down, A_down_p});
        else n_pass++;
        repeat (2) step();
        RST_N = 1'b1;
        for (int c = 1; c <= 7; c++) begin
            step();
            if (c == 6) p6 = A_down_p;
            if (c == 7) l7 = L_PADDLE_POSITION;
        end
        n_total++;
        if (p6 !== 1'b1) $display("FAIL mid_restart_pulse: got %b want 1", p6);
        else n_pass++;
        n_total++;
        if (l7 !== 11'd8) $display("FAIL mid_restart_L: got %0d want 8", l7);
        else n_pass++;
    endtask

    task automatic test_independent();
        logic [10:0] l6, r6;
        do_reset();
        A_UP_RAW = 1'b1;
        B_DOWN_RAW = 1'b1;
        for (int c = 1; c <= 7; c++) begin
            step();
            if (c == 6) begin l6 = L_PADDLE_POSITION; r6 = R_PADDLE_POSITION; end
        end
        n_total++;
        if ({l6, r6} !== {11'd7, 11'd7})
            $display("FAIL indep_c6: got L %0d R %0d want 7 7", l6, r6);
        else n_pass++;
        n_total++;
        if ({L_PADDLE_POSITION, R_PADDLE_POSITION} !== {11'd6, 11'd8})
            $display("FAIL indep_c7: got L %0d R %0d want 6 8",
                     L_PADDLE_POSITION, R_PADDLE_POSITION);
        else n_pass++;
    endtask

    initial begin
        n_pass = 0;
        n_total = 0;
        test_reset();
        test_glitch();
        test_press();
        test_repeat();
        test_both();
        test_hold();
        test_reset_mid();
        test_independent();
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
